// File: rtl/digit_deserializer.sv
// digit_deserializer
// Receive side of the 595-style seven-segment shift-register link.
// Oversamples ds/shcp/stcp/bl with clk, rebuilds each serial frame into a
// parallel word, flags frames with the wrong bit count and reports when no
// latch has been seen for a while.

module digit_deserializer #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ledsd_ds,
  input  logic             ledsd_shcp,
  input  logic             ledsd_stcp,
  input  logic             ledsd_bl,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             frame_err,
  output logic             blank,
  output logic             stale
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_PRE   = TMO_W'(TIMEOUT - 1);

  // Pin bundle order: {bl, stcp, shcp, ds}
  logic [3:0]       w_pins;
  logic [3:0]       w_sync;
  logic             w_shcpRise;
  logic             w_stcpRise;

  logic             r_prevShcp;
  logic             r_prevStcp;
  logic [WIDTH-1:0] r_sr;
  logic [CNT_W-1:0] r_bitCnt;
  logic [TMO_W-1:0] r_tmoCnt;
  logic [WIDTH-1:0] r_q;
  logic             r_qValid;
  logic             r_frameErr;
  logic             r_stale;

  assign w_pins = {ledsd_bl, ledsd_stcp, ledsd_shcp, ledsd_ds};

  generate
    if (SYNC_STAGES == 0) begin : g_noSync
      logic r_blank;

      assign w_sync = w_pins;

      // Source is already clk-synchronous; blank still gets one flop so no
      // pin reaches an output combinationally.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_blank <= 1'b0;
        else          r_blank <= w_pins[3];
      end

      assign blank = r_blank;
    end else begin : g_sync
      logic [3:0] r_chain [SYNC_STAGES];

      // All four pins share one chain so ds stays aligned with shcp.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) r_chain[i] <= '0;
        end else begin
          r_chain[0] <= w_pins;
          for (int i = 1; i < SYNC_STAGES; i++) r_chain[i] <= r_chain[i-1];
        end
      end

      assign w_sync = r_chain[SYNC_STAGES-1];
      assign blank  = w_sync[3];
    end
  endgenerate

  // One extra flop per clock pin gives the previous level for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prevShcp <= 1'b0;
      r_prevStcp <= 1'b0;
    end else begin
      r_prevShcp <= w_sync[1];
      r_prevStcp <= w_sync[2];
    end
  end

  assign w_shcpRise = w_sync[1] & ~r_prevShcp;
  assign w_stcpRise = w_sync[2] & ~r_prevStcp;

  // Shift register follows shcp; a coincident latch still sees the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_sr <= '0;
    else if (w_shcpRise) r_sr <= {r_sr[WIDTH-2:0], w_sync[0]};
  end

  // Bit counter saturates so an overlong frame can never wrap back to WIDTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bitCnt <= '0;
    end else if (w_stcpRise) begin
      r_bitCnt <= w_shcpRise ? CNT_ONE : '0;
    end else if (w_shcpRise && (r_bitCnt != CNT_MAX)) begin
      r_bitCnt <= r_bitCnt + 1'b1;
    end
  end

  // Latch the frame on stcp, judging its length by the pre-increment count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q        <= '0;
      r_qValid   <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_qValid <= 1'b0;
      if (w_stcpRise) begin
        r_q        <= r_sr;
        r_qValid   <= 1'b1;
        r_frameErr <= (r_bitCnt != CNT_FULL);
      end
    end
  end

  // Idle watchdog: stale rises the cycle the counter reaches its limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmoCnt <= '0;
      r_stale  <= 1'b0;
    end else if (w_stcpRise) begin
      r_tmoCnt <= '0;
      r_stale  <= 1'b0;
    end else begin
      if (r_tmoCnt != TMO_LIMIT) r_tmoCnt <= r_tmoCnt + 1'b1;
      r_stale <= (r_tmoCnt >= TMO_PRE);
    end
  end

  assign q         = r_q;
  assign q_valid   = r_qValid;
  assign frame_err = r_frameErr;
  assign stale     = r_stale;

endmodule
